// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, frame constants and the
// oversample divisor helper. ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_state_e;

  // Clocks per oversample tick, never below one.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned q;
    q = clk_hz / (baud * OVERSAMPLE);
    return (q < 32'd1) ? 32'd1 : q;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive byte buffer: wrap-around pointers plus occupancy count, head visible on dout.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(depth)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(depth); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(depth));
  assign empty = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with 2-of-3 majority voting and a byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity checked); default is 8N1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq       = 50000000,
  parameter int unsigned uart_baud_rate = 115200,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV    = baud_div(clk_freq, uart_baud_rate);
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  logic [1:0]           r_sync;
  logic                 r_rxd_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  uart_state_e          r_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_wait;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_err;
`endif

  logic w_rxd, w_fall, w_tick, w_vote, w_decide, w_bit_end;
  logic w_push, w_pop, w_full, w_empty;

  assign w_rxd     = r_sync[1];
  assign w_fall    = r_rxd_prev & ~w_rxd;
  assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_vote    = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd) | (r_samp[1] & w_rxd);
  assign w_decide  = w_tick && (r_tick_cnt == TICK_W'(9));
  assign w_bit_end = w_tick && (r_tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign w_pop     = rx_valid && rx_ready;
  assign rx_valid  = ~w_empty;
`ifdef UART_RX_PARITY_EN
  assign w_push = (r_state == ST_STOP) && !r_stop_wait && w_decide && w_vote && !r_par_err;
`else
  assign w_push = (r_state == ST_STOP) && !r_stop_wait && w_decide && w_vote;
`endif

  // Push is combinational so the byte lands in the buffer on the stop-bit decision edge.
  uart_fifo #(
    .width (DATA_BITS),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (rx_data),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync      <= 2'b11;
      r_rxd_prev  <= 1'b1;
      r_div_cnt   <= '0;
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_samp      <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], uart_rxd};
      r_rxd_prev <= w_rxd;
      r_div_cnt  <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      frame_err  <= 1'b0;
      overrun    <= w_push && w_full && !w_pop;

      if (w_tick && (r_state != ST_IDLE)) begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        if (r_tick_cnt == TICK_W'(7)) r_samp[0] <= w_rxd;
        if (r_tick_cnt == TICK_W'(8)) r_samp[1] <= w_rxd;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_decide && w_vote) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) begin
            if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
              r_stop_wait <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_state     <= ST_PARITY;
`else
              r_state     <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_decide) r_par_err <= w_vote ^ (^r_shift);
          if (w_bit_end) r_state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          // A low stop bit holds here until the line recovers, so a break is not seen as a start.
          if (r_stop_wait) begin
            if (w_rxd) begin
              r_state     <= ST_IDLE;
              r_stop_wait <= 1'b0;
            end
          end else if (w_decide) begin
            if (!w_vote) begin
              frame_err   <= 1'b1;
              r_stop_wait <= 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              frame_err <= r_par_err;
`endif
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed scenarios plus random bytes
// scored against a queue model of the receive buffer.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 16000000;
  localparam int unsigned BAUD     = 1000000;
  localparam int unsigned DEPTH    = 4;
  localparam int          BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .clk_freq       (CLK_FREQ),
    .uart_baud_rate (BAUD),
    .fifo_depth     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rxd  (uart_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         ferr_seen = 0, ovr_seen = 0, valid_cycles = 0;
  int         exp_ferr = 0, exp_ovr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest byte the model expects.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) ferr_seen++;
      if (overrun) ovr_seen++;
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_byte", {24'd0, rx_data}, 32'h100);
        else check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Buffer model: a good frame is queued, or counted as overrun when the consumer is stalled and full.
  task automatic model_good(input logic [7:0] b);
    if (!rx_ready && exp_q.size() >= int'(DEPTH)) exp_ovr++;
    else exp_q.push_back(b);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; glitch_bit/rst_bit index frame bits (0 = start), -1 disables.
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int glitch_bit, input int glitch_off, input int rst_bit);
    logic [10:0] bits;
    int          nbits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]  = ^b;
    bits[10] = stop_val;
    nbits = 11;
`else
    bits[9] = stop_val;
    nbits = 10;
`endif
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        uart_rxd = (i == glitch_bit && c == glitch_off) ? ~bits[i] : bits[i];
        if (i == rst_bit && c == 4) rst = 1'b0;
        if (i == rst_bit && c == 8) begin
          check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
          check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
          check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
          check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        end
        @(negedge clk);
      end
    end
    uart_rxd = 1'b1;
  endtask

  logic [7:0] burst [5];
  logic [7:0] rb;
  int         vc_snap;

  initial begin
    burst[0] = 8'hA3; burst[1] = 8'h0F; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;

    repeat (4) @(negedge clk);
    check_eq("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("reset_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    idle(20);

    // Single 0x55 with a ready consumer
    rx_ready = 1'b1;
    valid_cycles = 0;
    model_good(8'h55);
    send_frame(8'h55, 1'b1, -1, 0, -1);
    idle(20);
    check_eq("x55_valid_cycles", valid_cycles, 32'd1);
    check_eq("x55_drained", exp_q.size(), 32'd0);
    check_eq("x55_frame_err", ferr_seen, exp_ferr);
    check_eq("x55_overrun", ovr_seen, exp_ovr);

    // Back-to-back burst into a stalled consumer
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_good(burst[i]);
      send_frame(burst[i], 1'b1, -1, 0, -1);
    end
    idle(20);
    check_eq("burst_rx_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("burst_head", {24'd0, rx_data}, {24'd0, exp_q[0]});
    check_eq("burst_overrun", ovr_seen, exp_ovr);
    rx_ready = 1'b1;
    idle(10);
    check_eq("burst_drained", exp_q.size(), 32'd0);
    check_eq("burst_empty", {31'd0, rx_valid}, 32'd0);

    // Stop bit held low for one bit, then a clean frame
    exp_ferr++;
    send_frame(8'h3C, 1'b0, -1, 0, -1);
    idle(20);
    check_eq("ferr_count", ferr_seen, exp_ferr);
    check_eq("ferr_no_byte", {31'd0, rx_valid}, 32'd0);
    model_good(8'h12);
    send_frame(8'h12, 1'b1, -1, 0, -1);
    idle(20);
    check_eq("after_ferr_drained", exp_q.size(), 32'd0);
    check_eq("after_ferr_count", ferr_seen, exp_ferr);

    // Short low glitch on an idle line
    vc_snap = valid_cycles;
    uart_rxd = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check_eq("glitch_no_valid", valid_cycles, vc_snap);
    check_eq("glitch_frame_err", ferr_seen, exp_ferr);
    check_eq("glitch_overrun", ovr_seen, exp_ovr);

    // One-clock inverted pulse mid data bit 3 of 0x00 is out-voted
    model_good(8'h00);
    send_frame(8'h00, 1'b1, 4, 9, -1);
    idle(20);
    check_eq("vote_drained", exp_q.size(), 32'd0);
    check_eq("vote_frame_err", ferr_seen, exp_ferr);

    // Reset during data bit 4; held until the line idles, then a fresh frame
    vc_snap = valid_cycles;
    send_frame(8'h5A, 1'b1, -1, 0, 5);
    idle(10);
    rst = 1'b1;
    idle(20);
    check_eq("rst_no_byte", valid_cycles, vc_snap);
    check_eq("rst_no_ferr", ferr_seen, exp_ferr);
    model_good(8'h7E);
    send_frame(8'h7E, 1'b1, -1, 0, -1);
    idle(20);
    check_eq("post_rst_drained", exp_q.size(), 32'd0);

    // Random bytes with random idle gaps
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      model_good(rb);
      send_frame(rb, 1'b1, -1, 0, -1);
      idle(int'($urandom_range(0, 24)));
    end
    idle(20);
    check_eq("rand_drained", exp_q.size(), 32'd0);
    check_eq("rand_frame_err", ferr_seen, exp_ferr);
    check_eq("rand_overrun", ovr_seen, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter clk_freq, default 50000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter uart_baud_rate, default 115200, line bit rate in baud.
REQ-003 The block SHALL have parameter fifo_depth, default 4, receive buffer entries (power of two, 2..16).
REQ-004 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data  output  8  head-of-buffer byte.
REQ-008 The block SHALL have port rx_valid  output  1  buffer non-empty.
REQ-009 The block SHALL have port rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse per bad stop bit.
REQ-011 The block SHALL have port overrun  output  1  one-cycle pulse per byte dropped because the buffer is full.

Function
REQ-012 The block SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 The block SHALL generate a 16x oversample tick with divisor = max(1, floor(clk_freq/(uart_baud_rate*16))); the divisor counter SHALL run freely and wrap to 0.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP (PARITY when enabled); in IDLE a synchronized 1->0 transition SHALL enter START and clear the tick counter.
REQ-015 Each bit SHALL be decided by a 2-of-3 majority of the samples at ticks 7, 8, 9; the bit period ends at tick 15.
REQ-016 START sampling 1 SHALL be a false start: return to IDLE with no output and no error.
REQ-017 DATA SHALL shift 8 bits LSB first, then go to STOP.
REQ-018 STOP sampling 1 SHALL write the byte to the buffer (or pulse overrun if full) and return to IDLE immediately after tick 9, leaving half a bit period for the next start edge.
REQ-019 STOP sampling 0 SHALL discard the byte, pulse frame_err, and return to IDLE only after the line is sampled high.
REQ-020 The buffer SHALL be FIFO ordered, using wrap-around read/write pointers and an occupancy count; rx_data SHALL be valid in the same cycle as rx_valid.
REQ-021 A simultaneous write and pop when full SHALL be accepted (count unchanged, no overrun); a pop when empty SHALL be ignored.
REQ-022 The latency from the sampling of the stop bit to rx_valid asserted on an empty buffer SHALL be 1 clock.

Reset
REQ-023 While rst==0 at a clock edge, the block SHALL set the FSM to IDLE, clear the counters and pointers, set rx_valid=0, rx_data=0, frame_err=0, overrun=0, and set the synchronizer to 1.
REQ-024 A reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL restart only on a new 1->0 edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA and check even parity; on mismatch the byte SHALL be discarded and frame_err pulsed after STOP.
REQ-026 Without UART_RX_PARITY_EN the frame SHALL be 8N1 and no parity logic SHALL exist.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state encoding, the constants OVERSAMPLE=16 and DATA_BITS=8, and the divisor function.
REQ-028 The buffer SHALL be a sub-module uart_fifo (parameters width and depth; ports push/pop/full/empty); the FSM and sampler SHALL remain in uart_rx.

Verification (clk_freq=16000000, uart_baud_rate=1000000, 16 clk/bit)
REQ-029 Send 0x55 8N1 with rx_ready=1 -> rx_valid for 1 cycle with rx_data=0x55, no error pulses.
REQ-030 Send 0xA3, 0x0F, 0xFF, 0x00, 0x81 back-to-back with rx_ready=0 -> 4 bytes buffered, 1 overrun pulse; then rx_ready=1 -> pops A3, 0F, FF, 00 in order.
REQ-031 Send 0x3C with the stop bit held low for 1 bit, then release -> frame_err pulses once, no byte, next frame 0x12 received correctly.
REQ-032 Apply a 5-clock low glitch on an idle line -> false start, no output, no errors.
REQ-033 Apply a 1-clock inverted glitch at tick 8 of data bit 3 of 0x00 -> majority vote yields 0x00.
REQ-034 Assert rst during bit 4 of a frame -> all outputs 0, no byte delivered; next full frame 0x7E received.
